subtractor_pipe: RTL and testbench

SUBTRACTOR_PIPE -- requirements
Module: subtractor_pipe

---
 rtl/subtractor_pipe.sv | 184 ++++++++++++++++++
 tb/tb_subtractor_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subtractor_pipe.sv
// ---------------------------------------------------------------------------
// subtractor_pipe
//
// Pipelined unsigned subtractor with valid/ready handshaking. The operands are
// split into SEG_W-bit segments. Stage k resolves segment k of DIFF using the
// borrow produced by stage k-1. The upper operand segments travel down the
// pipe alongside the partial result, so every stage works on one transaction.
// The final stage registers are the outputs.
//
// Parameters
//   WIDTH  operand/result width (positive multiple of SEG_W)
//   SEG_W  bits resolved per stage; STAGES = WIDTH / SEG_W = latency
//
// Ports
//   CLK         clock, rising edge
//   RST         synchronous active-high reset
//   IN_VALID    operand pair offered
//   IN_READY    operand pair accepted this cycle (combinational)
//   A, B        minuend, subtrahend
//   OUT_VALID   result present
//   OUT_READY   consumer takes the result
//   DIFF        A-B modulo 2^WIDTH
//   BORROW_OUT  unsigned A<B
//   EQ          A==B
//   OVF, SLT    signed overflow / signed A<B; present only when the macro
//               SUBTRACTOR_SIGNED_FLAGS_EN is defined
// ---------------------------------------------------------------------------
module subtractor_pipe #(
    parameter int WIDTH = 8,
    parameter int SEG_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] DIFF,
    output logic             BORROW_OUT,
    output logic             EQ
`ifdef SUBTRACTOR_SIGNED_FLAGS_EN
    ,
    output logic             OVF,
    output logic             SLT
`endif
);

    localparam int STAGES = WIDTH / SEG_W;

    // Stage registers; index k holds the state after stage k.
    logic [STAGES-1:0] valid_r;
    logic [WIDTH-1:0]  a_r    [STAGES];
    logic [WIDTH-1:0]  b_r    [STAGES];
    logic [WIDTH-1:0]  diff_r [STAGES];
    logic [STAGES-1:0] borrow_r;
    logic [STAGES-1:0] eq_r;

    // Inputs seen by each stage: stage 0 takes the ports, stage k the
    // registers of stage k-1.
    logic [STAGES-1:0] src_valid_s;
    logic [WIDTH-1:0]  src_a_s    [STAGES];
    logic [WIDTH-1:0]  src_b_s    [STAGES];
    logic [WIDTH-1:0]  src_diff_s [STAGES];
    logic [STAGES-1:0] src_borrow_s;
    logic [STAGES-1:0] src_eq_s;

    // Combinational result of each stage.
    logic [SEG_W:0]    seg_s      [STAGES];
    logic [WIDTH-1:0]  diff_nxt_s [STAGES];
    logic [STAGES-1:0] borrow_nxt_s;
    logic [STAGES-1:0] eq_nxt_s;

    logic advance_s;

    // The whole pipe moves together whenever the output slot is free or taken.
    always_comb begin
        advance_s = !valid_r[STAGES-1] || OUT_READY;
    end

    assign IN_READY = advance_s;

    // Route each stage's source: ports for stage 0, previous registers otherwise.
    always_comb begin
        src_valid_s     = {STAGES{1'b0}};
        src_borrow_s    = {STAGES{1'b0}};
        src_eq_s        = {STAGES{1'b0}};
        src_a_s[0]      = A;
        src_b_s[0]      = B;
        src_diff_s[0]   = {WIDTH{1'b0}};
        src_valid_s[0]  = IN_VALID;
        src_borrow_s[0] = 1'b0;
        src_eq_s[0]     = 1'b1;
        for (int k = 1; k < STAGES; k++) begin
            src_a_s[k]      = a_r[k-1];
            src_b_s[k]      = b_r[k-1];
            src_diff_s[k]   = diff_r[k-1];
            src_valid_s[k]  = valid_r[k-1];
            src_borrow_s[k] = borrow_r[k-1];
            src_eq_s[k]     = eq_r[k-1];
        end
    end

    // Per-stage segment subtract; the extra MSB of seg_s is the borrow out.
    always_comb begin
        borrow_nxt_s = {STAGES{1'b0}};
        eq_nxt_s     = {STAGES{1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            seg_s[k] = {1'b0, src_a_s[k][k*SEG_W +: SEG_W]}
                     - {1'b0, src_b_s[k][k*SEG_W +: SEG_W]}
                     - {{SEG_W{1'b0}}, src_borrow_s[k]};
            diff_nxt_s[k] = src_diff_s[k];
            diff_nxt_s[k][k*SEG_W +: SEG_W] = seg_s[k][SEG_W-1:0];
            borrow_nxt_s[k] = seg_s[k][SEG_W];
            eq_nxt_s[k]     = src_eq_s[k] &
                              (src_a_s[k][k*SEG_W +: SEG_W] == src_b_s[k][k*SEG_W +: SEG_W]);
        end
    end

    // Stage registers: clear on reset, load on advance, otherwise hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_r  <= {STAGES{1'b0}};
            borrow_r <= {STAGES{1'b0}};
            eq_r     <= {STAGES{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]    <= {WIDTH{1'b0}};
                b_r[k]    <= {WIDTH{1'b0}};
                diff_r[k] <= {WIDTH{1'b0}};
            end
        end else if (advance_s) begin
            valid_r  <= src_valid_s;
            borrow_r <= borrow_nxt_s;
            eq_r     <= eq_nxt_s;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]    <= src_a_s[k];
                b_r[k]    <= src_b_s[k];
                diff_r[k] <= diff_nxt_s[k];
            end
        end else begin
            valid_r  <= valid_r;
            borrow_r <= borrow_r;
            eq_r     <= eq_r;
        end
    end

    assign OUT_VALID  = valid_r[STAGES-1];
    assign DIFF       = diff_r[STAGES-1];
    assign BORROW_OUT = borrow_r[STAGES-1];
    assign EQ         = eq_r[STAGES-1];

`ifdef SUBTRACTOR_SIGNED_FLAGS_EN
    logic ovf_s;
    logic slt_s;
    logic ovf_r;
    logic slt_r;

    // Signed overflow: operand signs differ and the result sign differs from A.
    always_comb begin
        ovf_s = (src_a_s[STAGES-1][WIDTH-1] ^ src_b_s[STAGES-1][WIDTH-1]) &
                (diff_nxt_s[STAGES-1][WIDTH-1] ^ src_a_s[STAGES-1][WIDTH-1]);
        slt_s = diff_nxt_s[STAGES-1][WIDTH-1] ^ ovf_s;
    end

    // Signed flags share the final stage's timing and hold behaviour.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_r <= 1'b0;
            slt_r <= 1'b0;
        end else if (advance_s) begin
            ovf_r <= ovf_s;
            slt_r <= slt_s;
        end else begin
            ovf_r <= ovf_r;
            slt_r <= slt_r;
        end
    end

    assign OVF = ovf_r;
    assign SLT = slt_r;
`endif

endmodule

// File: tb/tb_subtractor_pipe.sv
// ---------------------------------------------------------------------------
// tb_subtractor_pipe
//
// Directed-vector bench for subtractor_pipe (WIDTH=8, SEG_W=4, latency 2).
// Expected results are hand-computed in the vector table; the driver pushes
// the expected entry into a scoreboard queue when the DUT accepts the input,
// and an independent monitor pops and compares on every output transfer.
// ---------------------------------------------------------------------------
module tb_subtractor_pipe;

    localparam int WIDTH = 8;
    localparam int SEG_W = 4;
    localparam int NV    = 12;

    // Hand-computed vectors: A, B, DIFF, BORROW, EQ, OVF, SLT
    localparam logic [7:0] VA   [NV] = '{8'h35, 8'h10, 8'h00, 8'hA5, 8'hA5, 8'h80,
                                         8'h01, 8'hFF, 8'h7F, 8'h12, 8'hF0, 8'h3C};
    localparam logic [7:0] VB   [NV] = '{8'h12, 8'h01, 8'h01, 8'hA5, 8'hA4, 8'h01,
                                         8'h80, 8'hFF, 8'hFF, 8'h34, 8'h0F, 8'h3D};
    localparam logic [7:0] VD   [NV] = '{8'h23, 8'h0F, 8'hFF, 8'h00, 8'h01, 8'h7F,
                                         8'h81, 8'h00, 8'h80, 8'hDE, 8'hE1, 8'hFF};
    localparam logic       VBOR [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                         1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam logic       VEQ  [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic       VOVF [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                         1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic       VSLT [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                                         1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    typedef struct packed {
        logic [7:0] diff;
        logic       borrow;
        logic       eq;
        logic       ovf;
        logic       slt;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] A;
    logic [7:0] B;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [7:0] DIFF;
    logic       BORROW_OUT;
    logic       EQ;
`ifdef SUBTRACTOR_SIGNED_FLAGS_EN
    logic       OVF;
    logic       SLT;
`endif

    exp_t sb_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_pushed  = 0;
    int   n_popped  = 0;
    int   n_discard = 0;

    always #5 CLK = ~CLK;

    subtractor_pipe #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .A          (A),
        .B          (B),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .DIFF       (DIFF),
        .BORROW_OUT (BORROW_OUT),
        .EQ         (EQ)
`ifdef SUBTRACTOR_SIGNED_FLAGS_EN
        ,
        .OVF        (OVF),
        .SLT        (SLT)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer vector i until accepted; push its expectation at acceptance.
    // Called at posedge+1, returns at posedge+1 just after the accepting edge.
    task automatic send(input int i, output int waits);
        exp_t e;
        bit   done;
        waits    = 0;
        done     = 1'b0;
        A        = VA[i];
        B        = VB[i];
        IN_VALID = 1'b1;
        while (!done) begin
            @(negedge CLK);
            if (IN_READY === 1'b1 && RST === 1'b0) begin
                e.diff   = VD[i];
                e.borrow = VBOR[i];
                e.eq     = VEQ[i];
                e.ovf    = VOVF[i];
                e.slt    = VSLT[i];
                sb_q.push_back(e);
                n_pushed++;
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 20) begin
                    check("send_timeout", {31'd0, IN_READY}, 32'd1);
                    done = 1'b1;
                end
            end
            @(posedge CLK);
            #1;
        end
    endtask

    // Monitor: compare every output transfer against the scoreboard and
    // verify the output holds while stalled.
    initial begin : monitor
        exp_t       e;
        bit         hold_prev;
        logic [7:0] diff_prev;
        hold_prev = 1'b0;
        diff_prev = 8'h00;
        forever begin
            @(negedge CLK);
            if (RST === 1'b0) begin
                if (hold_prev) begin
                    check("hold_valid", {31'd0, OUT_VALID}, 32'd1);
                    check("hold_diff", {24'd0, DIFF}, {24'd0, diff_prev});
                end
                if (OUT_VALID === 1'b1 && OUT_READY === 1'b0)
                    check("in_ready_stall", {31'd0, IN_READY}, 32'd0);
                if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_out", {31'd0, OUT_VALID}, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        n_popped++;
                        check("diff", {24'd0, DIFF}, {24'd0, e.diff});
                        check("borrow_out", {31'd0, BORROW_OUT}, {31'd0, e.borrow});
                        check("eq", {31'd0, EQ}, {31'd0, e.eq});
`ifdef SUBTRACTOR_SIGNED_FLAGS_EN
                        check("ovf", {31'd0, OVF}, {31'd0, e.ovf});
                        check("slt", {31'd0, SLT}, {31'd0, e.slt});
`endif
                    end
                end
                hold_prev = (OUT_VALID === 1'b1) && (OUT_READY === 1'b0);
                diff_prev = DIFF;
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int w;
        int total;
        int cnt;
        RST       = 1'b1;
        IN_VALID  = 1'b0;
        A         = 8'h00;
        B         = 8'h00;
        OUT_READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("rst_diff", {24'd0, DIFF}, 32'd0);
        check("rst_borrow", {31'd0, BORROW_OUT}, 32'd0);
        check("rst_eq", {31'd0, EQ}, 32'd0);
`ifdef SUBTRACTOR_SIGNED_FLAGS_EN
        check("rst_ovf", {31'd0, OVF}, 32'd0);
        check("rst_slt", {31'd0, SLT}, 32'd0);
`endif
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Latency: result appears exactly two edges after acceptance.
        send(0, w);
        IN_VALID = 1'b0;
        check("lat_edge1_valid", {31'd0, OUT_VALID}, 32'd0);
        @(posedge CLK);
        #1;
        check("lat_edge2_valid", {31'd0, OUT_VALID}, 32'd1);
        repeat (3) @(posedge CLK);
        #1;

        // Back-to-back burst at full throughput.
        total = 0;
        for (int i = 1; i <= 5; i++) begin
            send(i, w);
            total += w;
        end
        IN_VALID = 1'b0;
        check("burst_waits", total, 32'd0);
        repeat (4) @(posedge CLK);
        #1;

        // Four pairs with a 3-cycle output stall.
        total = 0;
        fork
            begin
                for (int i = 6; i <= 9; i++) begin
                    send(i, w);
                    total += w;
                end
                IN_VALID = 1'b0;
            end
            begin
                @(posedge CLK);
                #1;
                @(posedge CLK);
                #1;
                OUT_READY = 1'b0;
                repeat (3) @(posedge CLK);
                #1;
                OUT_READY = 1'b1;
            end
        join
        check("stall_waits", total, 32'd3);
        repeat (6) @(posedge CLK);
        #1;

        // Reset with two transactions in flight and an input offered during reset.
        send(10, w);
        send(11, w);
        RST       = 1'b1;
        A         = VA[0];
        B         = VB[0];
        IN_VALID  = 1'b1;
        n_discard = n_discard + sb_q.size();
        sb_q.delete();
        @(posedge CLK);
        #1;
        check("midrst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("midrst_diff", {24'd0, DIFF}, 32'd0);
        check("midrst_borrow", {31'd0, BORROW_OUT}, 32'd0);
        check("midrst_eq", {31'd0, EQ}, 32'd0);
        RST      = 1'b0;
        IN_VALID = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(posedge CLK);
            #1;
            if (OUT_VALID !== 1'b0) cnt++;
        end
        check("no_stale_result", cnt, 32'd0);

        // Recovery after reset.
        send(5, w);
        send(8, w);
        IN_VALID = 1'b0;
        cnt = 0;
        while (sb_q.size() != 0 && cnt < 20) begin
            @(posedge CLK);
            #1;
            cnt++;
        end
        check("drain_empty", sb_q.size(), 32'd0);
        check("result_count", n_popped, n_pushed - n_discard);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
